// File: rtl/count1_key_sequencer.sv
// Key front-end for the 4-bit up/down counter: synchronises and debounces the add and direction
// keys, produces single-cycle add strobes with optional auto-repeat, and toggles the direction.
module count1_key_sequencer #(
    parameter int unsigned DEB_CYCLES    = 1_000_000,
    parameter bit          REPEAT_EN     = 1'b1,
    parameter int unsigned REPEAT_DELAY  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 5_000_000,
    parameter int unsigned TMR_W         = 25
) (
    input  logic FPGA_CLK,
    input  logic FPGA_RST_N,
    input  logic key_add_n,
    input  logic key_dir_n,
    output logic f_key_add,
    output logic f_key_direction,
    output logic f_key_held
);

    localparam logic [TMR_W-1:0] DebLast    = TMR_W'(DEB_CYCLES - 1);
    localparam logic [TMR_W-1:0] DelayLast  = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PeriodLast = TMR_W'(REPEAT_PERIOD - 1);
    localparam logic [TMR_W-1:0] TmrOne     = TMR_W'(1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StHold   = 2'd1;
    localparam logic [1:0] StRepeat = 2'd2;

    // Key index 0 is the add key, index 1 the direction key; levels are active-low.
    logic [1:0]            sync1_q, sync2_q;
    logic [1:0]            deb_q, deb_d;
    logic [1:0][TMR_W-1:0] deb_cnt_q, deb_cnt_d;
    logic                  dir_prev_q;
    logic [1:0]            state_q, state_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic                  add_q, add_d;
    logic                  pend_q, pend_d;
    logic                  dir_q, dir_d;
    logic                  add_pressed, dir_press, req;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            deb_d[k]     = deb_q[k];
            deb_cnt_d[k] = '0;
            if (sync2_q[k] != deb_q[k]) begin
                if (deb_cnt_q[k] == DebLast) begin
                    deb_d[k] = sync2_q[k];
                end else begin
                    deb_cnt_d[k] = deb_cnt_q[k] + TmrOne;
                end
            end
        end
    end

    assign add_pressed = ~deb_q[0];
    assign dir_press   = ~deb_q[1] & dir_prev_q;

    // Release is tested ahead of timer expiry so a simultaneous expiry yields no pulse.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        req     = 1'b0;
        case (state_q)
            StIdle: begin
                if (add_pressed) begin
                    req     = 1'b1;
                    tmr_d   = '0;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (!add_pressed) begin
                    tmr_d   = '0;
                    state_d = StIdle;
                end else if (REPEAT_EN && (tmr_q == DelayLast)) begin
                    req     = 1'b1;
                    tmr_d   = '0;
                    state_d = StRepeat;
                end else begin
                    tmr_d = tmr_q + TmrOne;
                end
            end
            StRepeat: begin
                if (!add_pressed) begin
                    tmr_d   = '0;
                    state_d = StIdle;
                end else if (tmr_q == PeriodLast) begin
                    req   = 1'b1;
                    tmr_d = '0;
                end else begin
                    tmr_d = tmr_q + TmrOne;
                end
            end
            default: begin
                tmr_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // A strobe coinciding with a direction toggle waits one cycle so it sees the new direction.
    always_comb begin
        add_d  = 1'b0;
        pend_d = 1'b0;
        dir_d  = dir_q ^ dir_press;
        if (dir_press) begin
            pend_d = req | pend_q;
        end else begin
            add_d = req | pend_q;
        end
    end

    always_ff @(posedge FPGA_CLK or negedge FPGA_RST_N) begin
        if (!FPGA_RST_N) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            deb_q      <= 2'b11;
            deb_cnt_q  <= '0;
            dir_prev_q <= 1'b1;
            state_q    <= StIdle;
            tmr_q      <= '0;
            add_q      <= 1'b0;
            pend_q     <= 1'b0;
            dir_q      <= 1'b1;
        end else begin
            sync1_q    <= {key_dir_n, key_add_n};
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_cnt_q  <= deb_cnt_d;
            dir_prev_q <= deb_q[1];
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            add_q      <= add_d;
            pend_q     <= pend_d;
            dir_q      <= dir_d;
        end
    end

    assign f_key_add       = add_q;
    assign f_key_direction = dir_q;
    assign f_key_held      = (state_q != StIdle);

endmodule

// File: tb/tb_count1_key_sequencer.sv
// Bench for count1_key_sequencer: an event-level model checked every cycle, plus directed scenarios
// with hand-computed pulse timings and counter results.
module tb_count1_key_sequencer;

    localparam int unsigned DEB = 4;
    localparam int unsigned DLY = 16;
    localparam int unsigned PER = 8;

    logic FPGA_CLK   = 1'b0;
    logic FPGA_RST_N = 1'b0;
    logic key_add_n  = 1'b1;
    logic key_dir_n  = 1'b1;
    logic add_r, dir_r, held_r;
    logic add_n, dir_n, held_n;

    always #5 FPGA_CLK = ~FPGA_CLK;

    count1_key_sequencer #(
        .DEB_CYCLES(DEB), .REPEAT_EN(1'b1), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER), .TMR_W(8)
    ) u_dut (
        .FPGA_CLK(FPGA_CLK), .FPGA_RST_N(FPGA_RST_N), .key_add_n(key_add_n),
        .key_dir_n(key_dir_n), .f_key_add(add_r), .f_key_direction(dir_r), .f_key_held(held_r)
    );

    count1_key_sequencer #(
        .DEB_CYCLES(DEB), .REPEAT_EN(1'b0), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER), .TMR_W(8)
    ) u_norep (
        .FPGA_CLK(FPGA_CLK), .FPGA_RST_N(FPGA_RST_N), .key_add_n(key_add_n),
        .key_dir_n(key_dir_n), .f_key_add(add_n), .f_key_direction(dir_n), .f_key_held(held_n)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle)", name, act, exp);
        end
    endtask

    // Model state: key levels after the two-stage delay, accepted press flags, run lengths.
    logic ms1, ms2, md1, md2;
    bit   acc_add, acc_dir, acc_dir_prev;
    int   run_add, run_dir;
    int   cyc = 0;
    int   t_press;
    bit   m_dir;
    bit   pend [2];
    bit   exp_add [2];
    bit   exp_held;

    // Observations of the repeating instance for the directed scenarios.
    int         npr, npn, first_r;
    bit         saw_held;
    logic [3:0] dout;
    int         ptimes[$];

    task automatic model_reset();
        ms1 = 1'b1; ms2 = 1'b1; md1 = 1'b1; md2 = 1'b1;
        acc_add = 0; acc_dir = 0; acc_dir_prev = 0;
        run_add = 0; run_dir = 0; t_press = 0;
        m_dir = 1; exp_held = 0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 0;
            exp_add[i] = 0;
        end
    endtask

    task automatic model_step();
        bit cand [2];
        bit tog;
        int el;
        el      = cyc - t_press - 1;
        cand[0] = acc_add && (el == 0 || (el >= int'(DLY) && ((el - int'(DLY)) % int'(PER)) == 0));
        cand[1] = acc_add && (el == 0);
        tog     = acc_dir && !acc_dir_prev;
        exp_held = acc_add;
        m_dir   = m_dir ^ tog;
        for (int i = 0; i < 2; i++) begin
            if (tog) begin
                exp_add[i] = 0;
                pend[i]    = cand[i] | pend[i];
            end else begin
                exp_add[i] = cand[i] | pend[i];
                pend[i]    = 0;
            end
        end
        acc_dir_prev = acc_dir;
        // A level is accepted after DEB consecutive samples that disagree with the current one.
        run_add = ((!ms2) != acc_add) ? run_add + 1 : 0;
        if (run_add == int'(DEB)) begin
            acc_add = !acc_add;
            run_add = 0;
            if (acc_add) t_press = cyc;
        end
        run_dir = ((!md2) != acc_dir) ? run_dir + 1 : 0;
        if (run_dir == int'(DEB)) begin
            acc_dir = !acc_dir;
            run_dir = 0;
        end
        ms2 = ms1; ms1 = key_add_n;
        md2 = md1; md1 = key_dir_n;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge FPGA_CLK);
            #1;
            cyc++;
            if (!FPGA_RST_N) model_reset();
            else model_step();
            chk("add_rep", add_r, exp_add[0]);
            chk("add_norep", add_n, exp_add[1]);
            chk("dir_rep", dir_r, m_dir);
            chk("dir_norep", dir_n, m_dir);
            chk("held_rep", held_r, exp_held);
            chk("held_norep", held_n, exp_held);
            if (add_r === 1'b1) begin
                if (npr == 0) first_r = cyc;
                npr++;
                ptimes.push_back(cyc);
                dout = (dir_r === 1'b1) ? dout + 4'd1 : dout - 4'd1;
            end
            if (add_n === 1'b1) npn++;
            if (held_r === 1'b1) saw_held = 1;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge FPGA_CLK);
    endtask

    task automatic clear_obs();
        npr = 0; npn = 0; first_r = -1; saw_held = 0; dout = 4'd0;
        ptimes.delete();
    endtask

    int p0;

    initial begin
        clear_obs();
        cycles(3);
        chk("reset_add", add_r, 1'b0);
        chk("reset_dir", dir_r, 1'b1);
        chk("reset_held", held_r, 1'b0);
        FPGA_RST_N = 1'b1;
        cycles(5);

        // Clean press held 10 cycles.
        clear_obs();
        key_add_n = 1'b0; p0 = cyc;
        cycles(10);
        key_add_n = 1'b1;
        cycles(15);
        chk("clean_count", npr, 1);
        chk("clean_latency", first_r - p0, 7);
        chk("clean_held_seen", saw_held, 1);
        chk("clean_held_end", held_r, 1'b0);

        // Bounce: 2-cycle runs never reach the 4-cycle debounce window.
        clear_obs();
        for (int i = 0; i < 10; i++) begin
            key_add_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            cycles(2);
        end
        key_add_n = 1'b1;
        cycles(15);
        chk("bounce_count", npr, 0);
        chk("bounce_held", saw_held, 0);

        // Held 40 cycles: pulses at +7,+23,+31,+39; the +47 expiry meets the release and is dropped.
        clear_obs();
        key_add_n = 1'b0; p0 = cyc;
        cycles(40);
        key_add_n = 1'b1;
        cycles(20);
        chk("rep_count", npr, 4);
        if (ptimes.size() == 4) begin
            chk("rep_t0", ptimes[0] - p0, 7);
            chk("rep_t1", ptimes[1] - p0, 23);
            chk("rep_t2", ptimes[2] - p0, 31);
            chk("rep_t3", ptimes[3] - p0, 39);
        end
        chk("rep_dout", dout, 4'd4);

        // Direction and add pressed together: toggle first, strobe one cycle later, counts down.
        clear_obs();
        key_add_n = 1'b0; key_dir_n = 1'b0; p0 = cyc;
        cycles(10);
        key_add_n = 1'b1; key_dir_n = 1'b1;
        cycles(15);
        chk("coll_count", npr, 1);
        chk("coll_latency", first_r - p0, 8);
        chk("coll_dir", dir_r, 1'b0);
        chk("coll_dout", dout, 4'd15);

        // Reset while repeating with the key held.
        key_add_n = 1'b0;
        cycles(30);
        FPGA_RST_N = 1'b0;
        #1;
        chk("rst_async_add", add_r, 1'b0);
        chk("rst_async_dir", dir_r, 1'b1);
        chk("rst_async_held", held_r, 1'b0);
        cycles(3);
        clear_obs();
        FPGA_RST_N = 1'b1; p0 = cyc;
        cycles(10);
        key_add_n = 1'b1;
        cycles(20);
        chk("rst_count", npr, 1);
        chk("rst_latency", first_r - p0, 7);

        // Held 60 cycles: the non-repeating instance strobes once, the repeating one seven times.
        clear_obs();
        key_add_n = 1'b0;
        cycles(60);
        key_add_n = 1'b1;
        cycles(20);
        chk("norep_count", npn, 1);
        chk("rep60_count", npr, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
